// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seg_pkg
// Description : Shared types and defaults for the rider-presence / steering
//               enable controller (state encoding, weight thresholds, timer
//               widths).
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Controller states; the 2-bit encoding leaves one illegal code (2'd3).
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } steer_state_t;

    // Nominal rider-weight threshold on lft_ld + rght_ld and its hysteresis band.
    localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
    localparam logic [11:0] WT_HYSTERESIS_DEF = 12'h40;

    // Settle-timer widths: short for simulation, ~1.34 s at 50 MHz otherwise.
    localparam int TMR_W_FAST = 15;
    localparam int TMR_W_FULL = 26;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/steer_tmr.sv
`default_nettype none
// ============================================================================
// Module      : steer_tmr
// Description : Parameterised-width settle up-counter with synchronous clear
//               and an all-ones "full" flag.
// Revision    : 1.0 - initial release
// ============================================================================
module steer_tmr #(
    parameter int WIDTH = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic full_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear dominates, otherwise count up when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, asynchronously reset to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o = &cnt_q;

endmodule : steer_tmr
`default_nettype wire

// File: rtl/steer_en_sm.sv
`default_nettype none
// ============================================================================
// Module      : steer_en_sm
// Description : Rider-presence and steering-enable controller. Decides from
//               the left/right load-cell readings whether a rider is on the
//               platform and whether they have stood balanced long enough to
//               enable steering.
// Revision    : 1.0 - initial release
// ============================================================================
module steer_en_sm
    import seg_pkg::*;
#(
    parameter bit          fast_sim      = 1'b1,
    parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int TMR_W = fast_sim ? TMR_W_FAST : TMR_W_FULL;

    // Mounting needs the upper threshold, staying on only the lower one.
    localparam logic [12:0] ENTER_THR = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
    localparam logic [12:0] STAY_THR  = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

    steer_state_t state_q;
    steer_state_t state_d;
    logic         en_steer_q;
    logic         rider_off_q;
    logic         clr_tmr;
    logic         tmr_full;

    logic [12:0]  sum_w;
    logic [12:0]  diff_w;
    logic [12:0]  neg_diff_w;
    logic [12:0]  adiff_w;
    logic         diff_gt_1_4;
    logic         diff_gt_15_16;
    logic         sum_gt_min;

    // Load arithmetic. |lft - rght| never exceeds 12 bits; it is carried at
    // 13 bits only so the compares against the 13-bit sum are width-matched.
    always_comb begin
        sum_w         = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff_w        = {1'b0, lft_ld} - {1'b0, rght_ld};
        neg_diff_w    = 13'd0 - diff_w;
        adiff_w       = diff_w[12] ? neg_diff_w : diff_w;
        diff_gt_1_4   = adiff_w > (sum_w >> 2);
        diff_gt_15_16 = adiff_w > (sum_w - (sum_w >> 4));
        sum_gt_min    = (state_q == IDLE) ? (sum_w > ENTER_THR) : (sum_w >= STAY_THR);
    end

    // Next-state logic; rider loss always takes priority over balance checks.
    always_comb begin
        state_d = state_q;
        clr_tmr = 1'b0;
        case (state_q)
            IDLE: begin
                if (sum_gt_min) begin
                    state_d = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            WAIT: begin
                if (!sum_gt_min) begin
                    state_d = IDLE;
                end else if (diff_gt_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    state_d = STEER_EN;
                end
            end
            STEER_EN: begin
                if (!sum_gt_min) begin
                    state_d = IDLE;
                end else if (diff_gt_15_16) begin
                    state_d = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and Moore outputs registered together from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            en_steer_q  <= (state_d == STEER_EN);
            rider_off_q <= (state_d == IDLE);
        end
    end

    // Settle timer only runs while waiting for a balanced stance.
    steer_tmr #(
        .WIDTH (TMR_W)
    ) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_tmr || (state_q != WAIT)),
        .en_i   (1'b1),
        .full_o (tmr_full)
    );

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;

endmodule : steer_en_sm
`default_nettype wire

// File: tb/tb_steer_en_sm.sv
`default_nettype none
// ============================================================================
// Module      : tb_steer_en_sm
// Description : Self-checking bench for steer_en_sm (fast_sim=1, 15-bit timer).
//               Expected outputs are queued with the cycle at which they must
//               appear and compared by a monitor on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_steer_en_sm;

    localparam int FULL_CNT = 32768;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int          cyc;
    int          vectors;
    int          fails;

    int          exp_cyc_q[$];
    logic        exp_en_q[$];
    logic        exp_ro_q[$];
    string       exp_tag_q[$];

    steer_en_sm #(
        .fast_sim      (1'b1),
        .MIN_RIDER_WT  (12'h200),
        .WT_HYSTERESIS (12'h40)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            int    c;
            logic  e_en;
            logic  e_ro;
            string tag;
            c    = exp_cyc_q.pop_front();
            e_en = exp_en_q.pop_front();
            e_ro = exp_ro_q.pop_front();
            tag  = exp_tag_q.pop_front();
            vectors++;
            assert (c == cyc && en_steer === e_en && rider_off === e_ro) else begin
                fails++;
                $error("FAIL %s @cyc %0d (due %0d): en_steer=%b rider_off=%b, expected en_steer=%b rider_off=%b",
                       tag, cyc, c, en_steer, rider_off, e_en, e_ro);
            end
        end
    end

    // Queue an expectation for the outputs after rising edge number c.
    task automatic expect_at(input int c, input logic e_en, input logic e_ro, input string tag);
        exp_cyc_q.push_back(c);
        exp_en_q.push_back(e_en);
        exp_ro_q.push_back(e_ro);
        exp_tag_q.push_back(tag);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    initial begin
        int e;
        int r;
        vectors = 0;
        fails   = 0;
        rst_n   = 1'b0;
        drive(12'h150, 12'h150);

        // Reset held with a heavy balanced rider: outputs pinned to IDLE.
        tick(3);
        expect_at(cyc, 1'b0, 1'b1, "reset_hold");
        rst_n = 1'b1;
        expect_at(cyc + 1, 1'b0, 1'b0, "mount_1st_clk");
        tick(1);
        e = cyc;  // WAIT entered at this edge

        // Balanced exactly at the 1/4 threshold keeps counting; reset at count 20000.
        drive(12'h1E0, 12'h120);
        expect_at(e + 10000, 1'b0, 1'b0, "wait_counting");
        tick(20000);
        rst_n = 1'b0;
        expect_at(cyc, 1'b0, 1'b1, "reset_mid_timer");
        tick(2);
        expect_at(cyc, 1'b0, 1'b1, "reset_mid_timer_hold");
        drive(12'h150, 12'h150);
        rst_n = 1'b1;
        e = cyc + 1;

        // Full count required again after reset.
        expect_at(e,                1'b0, 1'b0, "remount");
        expect_at(e + FULL_CNT / 2, 1'b0, 1'b0, "remount_half");
        expect_at(e + FULL_CNT - 1, 1'b0, 1'b0, "en_not_early");
        expect_at(e + FULL_CNT,     1'b1, 1'b0, "en_on_time");
        tick(FULL_CNT + 1);

        // Lower hysteresis edge: 464 and exactly 448 stay enabled.
        drive(12'h0E8, 12'h0E8);
        expect_at(cyc + 1, 1'b1, 1'b0, "steer_sum464");
        tick(3);
        drive(12'h0E0, 12'h0E0);
        expect_at(cyc + 1, 1'b1, 1'b0, "steer_sum448");
        tick(3);

        // Step-off one foot: disable next clock, rider still present.
        drive(12'h2A0, 12'h000);
        expect_at(cyc + 1, 1'b0, 1'b0, "step_off");
        tick(1);

        // Gross imbalance in WAIT holds the timer cleared.
        drive(12'h200, 12'h0A0);
        expect_at(cyc + 500, 1'b0, 1'b0, "imbalance_hold");
        tick(1000);

        // Rebalance at the exact 1/4 boundary: full count from the last clear.
        drive(12'h1E0, 12'h120);
        r = cyc;
        expect_at(r + FULL_CNT - 1, 1'b0, 1'b0, "rebal_not_early");
        expect_at(r + FULL_CNT,     1'b1, 1'b0, "rebal_en");
        tick(FULL_CNT);

        // Sum 432 drops the rider.
        drive(12'h0D8, 12'h0D8);
        expect_at(cyc + 1, 1'b0, 1'b1, "loss_sum432");
        tick(1);

        // Upper hysteresis edge from IDLE: 560 and 576 stay, 578 mounts.
        drive(12'h118, 12'h118);
        expect_at(cyc + 1, 1'b0, 1'b1, "idle_sum560");
        tick(2);
        drive(12'h120, 12'h120);
        expect_at(cyc + 1, 1'b0, 1'b1, "idle_sum576");
        tick(2);
        drive(12'h121, 12'h121);
        expect_at(cyc + 1, 1'b0, 1'b0, "idle_sum578");
        tick(1);

        // Simultaneous loss and imbalance in WAIT: loss wins.
        drive(12'h1B0, 12'h000);
        expect_at(cyc + 1, 1'b0, 1'b1, "loss_beats_imbal");
        tick(2);

        // Bounded drain of any outstanding expectations.
        for (int i = 0; i < 10 && exp_cyc_q.size() > 0; i++) tick(1);
        if (exp_cyc_q.size() > 0) begin
            fails += exp_cyc_q.size();
            $display("FAIL drain: %0d expectations left, required 0", exp_cyc_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_steer_en_sm
`default_nettype wire
